// File: rtl/wvb_pkg.sv
// Shared constants for the waveform-buffer read engine: header field layout,
// frame marker, output word width and FSM state encoding.
package wvb_pkg;

    localparam int DOUT_W = 32;

    localparam logic [7:0] FRAME_MARKER = 8'hA5;

    // Header bit offsets (LSB of each field)
    localparam int HDR_LTC_LSB   = 39;
    localparam int HDR_START_LSB = 24;
    localparam int HDR_STOP_LSB  = 9;
    localparam int HDR_TRIG_LSB  = 7;
    localparam int HDR_CNST_BIT  = 6;
    localparam int HDR_PRE_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_H0   = 3'd2,
        ST_H1   = 3'd3,
        ST_H2   = 3'd4,
        ST_DATA = 3'd5,
        ST_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry FIFO that catches waveform buffer read data one cycle after the
// request, so the stream keeps going while the consumer stalls.
module wvb_rd_skid
    import wvb_pkg::*;
#(
    parameter int P_WIDTH = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [P_WIDTH-1:0] wr_data,
    output logic               rd_valid,
    output logic [P_WIDTH-1:0] rd_data,
    input  logic               rd_ready,
    output logic [1:0]         count
);

    logic [P_WIDTH-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic               do_wr;
    logic               do_rd;

    assign do_rd = rd_ready && (count_q != 2'd0);
    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_wr = wr_en && ((count_q != 2'd2) || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end

    assign rd_valid = (count_q != 2'd0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/wvb_reader.sv
// Read-side engine of the waveform buffer: pops one header, then frames the
// header words and the event's samples as a 32-bit valid/ready stream.
module wvb_reader
    import wvb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 28,
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_HDR_WIDTH  = 87,
    parameter int P_LTC_WIDTH  = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    output logic [DOUT_W-1:0]       dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    busy,
    output logic [15:0]             evt_cnt
);

    state_e                   state_q, state_d;
    logic [P_LTC_WIDTH-1:0]   ltc_q;
    logic [P_ADR_WIDTH-1:0]   start_q;
    logic [1:0]               trig_q;
    logic                     cnst_q;
    logic [15:0]              n_words_q;
    logic [15:0]              req_cnt_q;
    logic [15:0]              rem_q;
    logic                     inflight_q;
    logic [15:0]              evt_cnt_q;

    logic [P_LTC_WIDTH-1:0]   hdr_ltc;
    logic [P_ADR_WIDTH-1:0]   hdr_start;
    logic [P_ADR_WIDTH-1:0]   hdr_stop;
    logic [P_ADR_WIDTH-1:0]   addr_span;
    logic [15:0]              hdr_n_words;
    logic                     unused_pre_conf;

    logic                     skid_valid;
    logic [P_DATA_WIDTH-1:0]  skid_data;
    logic [1:0]               skid_count;
    logic                     skid_pop;
    logic                     fetch_phase;
    logic [2:0]               occupancy;

    assign hdr_ltc         = hdr_data[HDR_LTC_LSB +: P_LTC_WIDTH];
    assign hdr_start       = hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
    assign hdr_stop        = hdr_data[HDR_STOP_LSB +: P_ADR_WIDTH];
    assign unused_pre_conf = ^hdr_data[HDR_PRE_W-1:0];
    // Modulo-2^ADR subtraction handles events that wrap around the buffer end.
    assign addr_span       = hdr_stop - hdr_start;
    assign hdr_n_words     = 16'(addr_span) + 16'd1;

    assign fetch_phase = (state_q == ST_H0) || (state_q == ST_H1) ||
                         (state_q == ST_H2) || (state_q == ST_DATA);
    assign skid_pop    = (state_q == ST_DATA) && skid_valid && dout_ready;
    // Credit the word leaving this cycle so DATA sustains one word per cycle.
    assign occupancy   = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};
    assign wvb_rdreq   = fetch_phase && (req_cnt_q < n_words_q) && (occupancy < 3'd2);

    wvb_rd_skid #(
        .P_WIDTH (P_DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (inflight_q),
        .wr_data  (wvb_data),
        .rd_valid (skid_valid),
        .rd_data  (skid_data),
        .rd_ready (skid_pop),
        .count    (skid_count)
    );

    always_comb begin
        state_d    = state_q;
        hdr_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        dout_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !hdr_empty) state_d = ST_POP;
            end
            ST_POP: begin
                if (!hdr_empty) begin
                    hdr_rdreq = 1'b1;
                    state_d   = ST_H0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_H0: begin
                dout_valid = 1'b1;
                dout       = {FRAME_MARKER, 4'h0, trig_q, cnst_q, 1'b0, n_words_q};
                if (dout_ready) state_d = ST_H1;
            end
            ST_H1: begin
                dout_valid = 1'b1;
                dout       = ltc_q[47:16];
                if (dout_ready) state_d = ST_H2;
            end
            ST_H2: begin
                dout_valid = 1'b1;
                dout       = {ltc_q[15:0], 1'b0, start_q};
                if (dout_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                dout_valid = skid_valid;
                dout       = {{(DOUT_W-P_DATA_WIDTH){1'b0}}, skid_data};
                dout_last  = skid_valid && (rem_q == 16'd1);
                if (skid_pop && (rem_q == 16'd1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                wvb_rddone = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ltc_q      <= '0;
            start_q    <= '0;
            trig_q     <= 2'b00;
            cnst_q     <= 1'b0;
            n_words_q  <= 16'd0;
            req_cnt_q  <= 16'd0;
            rem_q      <= 16'd0;
            inflight_q <= 1'b0;
            evt_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= wvb_rdreq;
            if (hdr_rdreq) begin
                ltc_q     <= hdr_ltc;
                start_q   <= hdr_start;
                trig_q    <= hdr_data[HDR_TRIG_LSB +: 2];
                cnst_q    <= hdr_data[HDR_CNST_BIT];
                n_words_q <= hdr_n_words;
                rem_q     <= hdr_n_words;
                req_cnt_q <= 16'd0;
            end else begin
                if (wvb_rdreq) req_cnt_q <= req_cnt_q + 16'd1;
                if (skid_pop)  rem_q     <= rem_q - 16'd1;
            end
            if (state_q == ST_DONE) evt_cnt_q <= evt_cnt_q + 16'd1;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader with header FIFO / waveform buffer models and
// a frame-level expectation queue checked on every accepted word.
module tb_wvb_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        hdr_empty = 1'b1;
    logic [86:0] hdr_data = '0;
    logic [27:0] wvb_data = '0;
    logic        dout_ready = 1'b0;
    logic        hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_last, busy;
    logic [31:0] dout;
    logic [15:0] evt_cnt;

    wvb_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hdr_empty  (hdr_empty),
        .hdr_data   (hdr_data),
        .hdr_rdreq  (hdr_rdreq),
        .wvb_data   (wvb_data),
        .wvb_rdreq  (wvb_rdreq),
        .wvb_rddone (wvb_rddone),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .evt_cnt    (evt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [86:0] hdr_q [$];
    logic [32:0] exp_q [$];
    logic [31:0] cap [0:63];
    int ev_n = 0, ev_req = 0, ev_acc = 0, ev_data_acc = 0, last_pos = 0;
    int hdr_pops = 0, rdreq_total = 0, rddone_total = 0, exp_evt = 0;
    int rd_ptr = 0;
    logic pop_pend = 1'b0, req_pend = 1'b0, last_pend = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_dout = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [27:0] buf_word(input int a);
        logic [14:0] a15;
        a15 = a[14:0];
        return {a15[12:0] ^ 13'h1A5B, a15};
    endfunction

    function automatic logic [86:0] make_hdr(input logic [47:0] ltc, input logic [14:0] st,
                                             input logic [14:0] sp, input logic [1:0] tr,
                                             input logic cr);
        return {ltc, st, sp, tr, cr, 6'h2A};
    endfunction

    task automatic refresh_hdr();
        hdr_empty = (hdr_q.size() == 0);
        hdr_data  = (hdr_q.size() == 0) ? '0 : hdr_q[0];
    endtask

    task automatic push_hdr(input logic [86:0] h);
        hdr_q.push_back(h);
        refresh_hdr();
    endtask

    // Build the whole expected frame for one header straight from the field rules.
    task automatic expect_frame(input logic [86:0] h);
        logic [47:0] ltc;
        logic [14:0] st, sp;
        logic [1:0]  tr;
        logic        cr;
        int          n;
        logic [31:0] w0;
        ltc = h[86:39]; st = h[38:24]; sp = h[23:9]; tr = h[8:7]; cr = h[6];
        n  = ((int'(sp) - int'(st) + 32768) % 32768) + 1;
        w0 = 32'hA500_0000 | (32'(tr) << 18) | (32'(cr) << 17) | 32'(n);
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({1'b0, ltc[47:16]});
        exp_q.push_back({1'b0, ltc[15:0], 1'b0, st});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), 4'h0, buf_word(int'(st) + i)});
        end
        ev_n = n; ev_req = 0; ev_acc = 0; ev_data_acc = 0; last_pos = 0;
        rd_ptr = int'(st);
    endtask

    // Header FIFO pop and buffer read data, applied just after the edge that consumed them.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pop_pend = 1'b0;
            req_pend = 1'b0;
        end else begin
            if (req_pend) begin
                wvb_data = buf_word(rd_ptr);
                rd_ptr   = (rd_ptr + 1) % 32768;
                req_pend = 1'b0;
            end
            if (pop_pend) begin
                if (hdr_q.size() != 0) expect_frame(hdr_q.pop_front());
                refresh_hdr();
                pop_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            last_pend  = 1'b0;
        end else begin
            if (hdr_rdreq) begin
                check("hdr_rdreq_while_empty", hdr_empty, 1'b0);
                hdr_pops++;
                pop_pend = 1'b1;
            end
            if (wvb_rdreq) begin
                rdreq_total++;
                ev_req++;
                req_pend = 1'b1;
                check("rdreq_le_n_words", ev_req <= ev_n, 1'b1);
            end
            if (prev_stall) begin
                check("hold_valid", dout_valid, 1'b1);
                check("hold_dout", dout, prev_dout);
                check("hold_last", dout_last, prev_last);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", dout, 32'hFFFF_FFFF);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("dout", dout, e[31:0]);
                    check("dout_last", dout_last, e[32]);
                end
                if (ev_acc < 64) cap[ev_acc] = dout;
                ev_acc++;
                if (ev_acc > 3) ev_data_acc++;
                if (dout_last) begin
                    last_pend = 1'b1;
                    last_pos  = ev_acc;
                end
            end
            check("outstanding_le_2", (ev_req - ev_data_acc) <= 2, 1'b1);
            if (wvb_rddone) begin
                check("rddone_after_last", last_pend, 1'b1);
                last_pend = 1'b0;
                rddone_total++;
            end
            check("evt_cnt", evt_cnt, exp_evt);
            if (wvb_rddone) exp_evt++;
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rddone(input int target, input int budget);
        int k;
        k = 0;
        while (rddone_total < target && k < budget) begin
            tick();
            k++;
        end
        check("event_timeout", rddone_total >= target, 1'b1);
        repeat (2) tick();
    endtask

    task automatic wait_progress(input int pops, input int acc, input int budget);
        int k;
        k = 0;
        while (!(hdr_pops >= pops && ev_acc >= acc) && k < budget) begin
            tick();
            k++;
        end
        check("progress_timeout", hdr_pops >= pops && ev_acc >= acc, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"}, dout, 32'h0);
        check({tag, "_dout_valid"}, dout_valid, 1'b0);
        check({tag, "_dout_last"}, dout_last, 1'b0);
        check({tag, "_hdr_rdreq"}, hdr_rdreq, 1'b0);
        check({tag, "_wvb_rdreq"}, wvb_rdreq, 1'b0);
        check({tag, "_wvb_rddone"}, wvb_rddone, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_evt_cnt"}, evt_cnt, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int rd_before;
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: single event
        en = 1'b1;
        dout_ready = 1'b1;
        push_hdr(make_hdr(48'h1234_5678_9ABC, 15'h0010, 15'h0013, 2'd1, 1'b0));
        wait_rddone(1, 200);
        check("t1_w0", cap[0], 32'hA504_0004);
        check("t1_w1", cap[1], 32'h1234_5678);
        check("t1_w2", cap[2], 32'h9ABC_0010);
        check("t1_data0_addr", cap[3][14:0], 15'h0010);
        check("t1_last_pos", last_pos, 7);
        check("t1_hdr_pops", hdr_pops, 1);
        check("t1_rdreq", rdreq_total, 4);
        check("t1_rddone", rddone_total, 1);
        check("t1_evt_cnt", evt_cnt, 16'd1);
        $display("event 1 single: words=%0d rdreq=%0d evt_cnt=%0d", ev_acc, rdreq_total, evt_cnt);

        // 2: address wrap
        push_hdr(make_hdr(48'hFEDC_BA98_7654, 15'h7FFE, 15'h0001, 2'd2, 1'b1));
        wait_rddone(2, 200);
        check("t2_w0", cap[0], 32'hA50A_0004);
        check("t2_d0", cap[3][14:0], 15'h7FFE);
        check("t2_d1", cap[4][14:0], 15'h7FFF);
        check("t2_d2", cap[5][14:0], 15'h0000);
        check("t2_d3", cap[6][14:0], 15'h0001);
        check("t2_rdreq", rdreq_total, 8);
        $display("event 2 wrap: words=%0d rdreq=%0d evt_cnt=%0d", ev_acc, rdreq_total, evt_cnt);

        // 3: backpressure mid-DATA, then toggling ready
        push_hdr(make_hdr(48'h0000_1111_2222, 15'h0100, 15'h0107, 2'd3, 1'b0));
        wait_progress(3, 5, 200);
        dout_ready = 1'b0;
        repeat (20) tick();
        k = 0;
        while (rddone_total < 3 && k < 400) begin
            dout_ready = ~dout_ready;
            tick();
            k++;
        end
        dout_ready = 1'b1;
        wait_rddone(3, 50);
        check("t3_rdreq", rdreq_total, 16);
        check("t3_words", ev_acc, 11);
        check("t3_exp_empty", exp_q.size(), 0);
        $display("event 3 backpressure: words=%0d rdreq=%0d evt_cnt=%0d", ev_acc, rdreq_total, evt_cnt);

        // 4: two queued headers back to back
        push_hdr(make_hdr(48'hAAAA_BBBB_CCCC, 15'h0200, 15'h0202, 2'd0, 1'b1));
        push_hdr(make_hdr(48'h0102_0304_0506, 15'h0300, 15'h0300, 2'd1, 1'b1));
        wait_rddone(5, 300);
        check("t4_evt_cnt", evt_cnt, 16'd5);
        check("t4_hdr_pops", hdr_pops, 5);
        check("t4_rddone", rddone_total, 5);
        check("t4_exp_empty", exp_q.size(), 0);
        $display("events 4-5 back-to-back: rdreq=%0d evt_cnt=%0d", rdreq_total, evt_cnt);

        // 5: en dropped during H1 with a second header queued
        push_hdr(make_hdr(48'h5555_6666_7777, 15'h0010, 15'h0014, 2'd2, 1'b0));
        push_hdr(make_hdr(48'h8888_9999_AAAA, 15'h0020, 15'h0021, 2'd3, 1'b1));
        wait_progress(6, 1, 200);
        en = 1'b0;
        wait_rddone(6, 200);
        repeat (20) tick();
        check("t5_no_pop_while_disabled", hdr_pops, 6);
        check("t5_hdr_left", hdr_q.size(), 1);
        check("t5_idle", busy, 1'b0);
        en = 1'b1;
        wait_rddone(7, 200);
        check("t5_hdr_pops", hdr_pops, 7);
        check("t5_evt_cnt", evt_cnt, 16'd7);
        $display("events 6-7 en gating: pops=%0d evt_cnt=%0d", hdr_pops, evt_cnt);

        // 6: asynchronous reset mid-DATA
        push_hdr(make_hdr(48'hDEAD_BEEF_0001, 15'h0400, 15'h040F, 2'd1, 1'b0));
        wait_progress(8, 6, 200);
        rd_before = rddone_total;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_evt = 0;
        ev_n = 0; ev_req = 0; ev_acc = 0; ev_data_acc = 0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_rddone", rddone_total, rd_before);
        check("t6_idle", busy, 1'b0);
        push_hdr(make_hdr(48'h0BAD_CAFE_0002, 15'h0500, 15'h0501, 2'd0, 1'b0));
        wait_rddone(rd_before + 1, 200);
        check("t6_evt_cnt", evt_cnt, 16'd1);
        check("t6_words", ev_acc, 5);
        check("t6_exp_empty", exp_q.size(), 0);
        $display("event 8 after reset: words=%0d evt_cnt=%0d", ev_acc, evt_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
